systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for an N×N systolic array of multiply-add processing elements (PEs). It accepts a tile-multiply command carrying the inner-dimension length `k`. For each command it:
- clears the array accumulators,
- streams `k` beats out of the operand feed buffers, generating the per-row skewed valid wavefront,
- waits out the array skew plus PE pipeline latency,
- hands the N result rows downstream over a valid/ready port.

It sits between the tile scheduler and the PE array and owns the array enable.

## Interface
Parameters:
- `N`, 4, array dimension (rows = columns); power of two, ≥2
- `K_W`, 8, width of `k` and of the feed read address
- `PE_LATENCY`, 4, cycles from PE operand capture to updated accumulator

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start_valid`  in  1  command offered
- `start_ready`  out  1  controller can accept a command (state IDLE)
- `start_k`  in  K_W  inner-dimension beats; sampled on accept
- `rd_en`  out  1  feed buffers read strobe; data returns next cycle
- `rd_addr`  out  K_W  feed beat index, 0..k-1
- `pe_enable`  out  1  global array clock-enable
- `pe_clear`  out  1  synchronous accumulator clear to array
- `row_valid`  out  N  skewed operand-valid, bit i for array row i
- `out_valid`  out  1  result row available
- `out_ready`  in  1  downstream accepts result row
- `out_row`  out  $clog2(N)  index of result row presented by array
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → OUT → DONE → IDLE.
- IDLE:
  - `start_ready`=1.
  - Accept on `start_valid`&&`start_ready`; latch `start_k`, go CLEAR.
- CLEAR:
  - one cycle; `pe_clear`=1, `pe_enable`=1.
  - → FEED if k≠0, else → DRAIN.
- FEED:
  - k cycles; `rd_en`=1, `rd_addr` counts 0..k-1.
  - → DRAIN after the beat with `rd_addr`=k-1.
- DRAIN:
  - exactly D = 1 + 2(N-1) + PE_LATENCY cycles (read latency + skew + PE pipeline); `pe_enable`=1.
  - → OUT.
- OUT:
  - `out_valid`=1; `out_row` starts at 0 and increments on each `out_valid`&&`out_ready`.
  - Hold `out_row` while `out_ready`=0.
  - After row N-1 transfers → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `pe_enable` is 0 in IDLE, OUT and DONE: the array freezes and holds its results for readout.
- `row_valid[i]` is asserted at cycle c+1+i for every FEED beat at cycle c. It is a registered delay of `rd_en` and is never gated by `out_ready`.
- k=0: FEED is skipped, the DRAIN length is unchanged, and the array outputs cleared (zero) results.
- `start_valid` outside IDLE is ignored; the command is not lost, only not accepted.
- The `k` counter is K_W+1 bits internally, so k=2^K_W-1 terminates without wrap.

## Timing
- Reset values (async, while `reset`=0):
  - state IDLE, `start_ready`=1;
  - all other outputs 0: `rd_en`, `rd_addr`, `pe_enable`, `pe_clear`, `row_valid`, `out_valid`, `out_row`, `busy`, `done`.
- Reset mid-operation aborts immediately to IDLE and clears skew registers. There is no partial completion and no `done`.
- All outputs are registered or decoded from the registered state; no combinational path from `out_ready` or `start_valid` to any output.
- Accept at cycle 0:
  - CLEAR at cycle 1;
  - FEED cycles 2..k+1;
  - DRAIN cycles k+2..k+1+D;
  - first `out_valid` at cycle k+2+D.
- With `out_ready` held high: rows at k+2+D .. k+1+D+N, `done` at k+2+D+N, `start_ready` at k+3+D+N.
- Back-to-back commands have a minimum gap of one IDLE cycle between `done` and the next accept.

## Structure
- Package `systolic_pkg`:
  - state enum `ctrl_state_t`;
  - `localparam` helper for D;
  - row-index width function shared with the array wrapper.
- One sub-module, `systolic_skew`: N-tap delay line producing `row_valid` from `rd_en`. Tap i has delay 1+i; async active-low reset clears all taps.
- FSM, `k` counter, drain counter and row counter live in `systolic_ctrl`.

## Test plan
- N=4, PE_LATENCY=4 (D=11), k=3, `out_ready`=1:
  - `pe_clear` at cycle 1;
  - `rd_addr` 0,1,2 at cycles 2–4;
  - `out_valid` at cycle 16, `out_row` 0..3 at cycles 16–19;
  - `done` at cycle 20.
- Same command; check `row_valid`: bit0 high cycles 3–5, bit3 high cycles 6–8, all bits low otherwise.
- k=0: no `rd_en`, `row_valid` stays 0, first `out_valid` at cycle 13, `done` at cycle 17.
- `out_ready` low 5 cycles on row 2: `out_row` holds 2, `pe_enable` stays 0, `done` is delayed exactly 5 cycles.
- `start_valid` held high throughout: second accept only in the cycle after `done`; `start_k` changes while busy have no effect.
- `reset` asserted during DRAIN of a k=3 command: outputs reach reset values in the same cycle, no `done`, and a new command after release completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM encoding and geometry helpers shared by the systolic controller and array wrapper.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT,
        S_DONE
    } ctrl_state_t;

    // Drain covers the feed read latency, the row/column skew and the PE pipeline.
    function automatic int drain_cycles(input int n, input int pe_latency);
        return 1 + 2 * (n - 1) + pe_latency;
    endfunction

    function automatic int row_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew.sv
// systolic_skew: N-tap delay line turning the feed read strobe into per-row skewed operand valids.
module systolic_skew #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [N-1:0] row_valid_o
);

    logic [N-1:0] tap_q;

    // Tap i lags the strobe by 1+i cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tap_q <= '0;
        else        tap_q <= {tap_q[N-2:0], en_i};
    end

    assign row_valid_o = tap_q;

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences clear, operand feed, drain and result readout for an NxN systolic array.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N          = 4,
    parameter int K_W        = 8,
    parameter int PE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [K_W-1:0]        start_k,
    output logic                  rd_en,
    output logic [K_W-1:0]        rd_addr,
    output logic                  pe_enable,
    output logic                  pe_clear,
    output logic [N-1:0]          row_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [row_w(N)-1:0]   out_row,
    output logic                  busy,
    output logic                  done
);

    localparam int D  = drain_cycles(N, PE_LATENCY);
    localparam int DW = $clog2(D);
    localparam int RW = row_w(N);

    ctrl_state_t   state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [K_W:0]   cnt_q, cnt_d;
    logic [DW-1:0]  drn_q, drn_d;
    logic [RW-1:0]  row_q, row_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    k_d     = start_k;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                drn_d   = '0;
                state_d = (k_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                // Extra counter bit lets k = 2^K_W-1 finish without wrapping.
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == {1'b0, k_q}) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == DW'(D - 1)) state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    row_d = row_q + 1'b1;
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start_ready = state_q == S_IDLE;
    assign busy        = state_q != S_IDLE;
    assign pe_clear    = state_q == S_CLEAR;
    assign rd_en       = state_q == S_FEED;
    assign rd_addr     = rd_en ? cnt_q[K_W-1:0] : '0;
    assign pe_enable   = state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN;
    assign out_valid   = state_q == S_OUT;
    assign out_row     = row_q;
    assign done        = state_q == S_DONE;

    systolic_skew #(.N(N)) u_skew (
        .clk         (clk),
        .reset       (reset),
        .en_i        (rd_en),
        .row_valid_o (row_valid)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized and directed checks of systolic_ctrl against a cycle-offset reference model.
module tb_systolic_ctrl;

    localparam int N   = 4;
    localparam int K_W = 8;
    localparam int PEL = 4;
    localparam int D   = 1 + 2 * (N - 1) + PEL;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_valid;
    logic           start_ready;
    logic [K_W-1:0] start_k;
    logic           rd_en;
    logic [K_W-1:0] rd_addr;
    logic           pe_enable;
    logic           pe_clear;
    logic [N-1:0]   row_valid;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_row;
    logic           busy;
    logic           done;

    systolic_ctrl #(.N(N), .K_W(K_W), .PE_LATENCY(PEL)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_k     (start_k),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .pe_enable   (pe_enable),
        .pe_clear    (pe_clear),
        .row_valid   (row_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;
    int acc_t = -1;
    int done_t = -1;

    // Reference model: a command accepted at cycle a with length k has fixed phase offsets.
    bit m_act = 0;
    int m_a, m_k, m_x, m_done_t;
    bit rlog [0:19999];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 1);
        chk({tag, "_rd_en"},       32'(rd_en), 0);
        chk({tag, "_rd_addr"},     32'(rd_addr), 0);
        chk({tag, "_pe_enable"},   32'(pe_enable), 0);
        chk({tag, "_pe_clear"},    32'(pe_clear), 0);
        chk({tag, "_row_valid"},   32'(row_valid), 0);
        chk({tag, "_out_valid"},   32'(out_valid), 0);
        chk({tag, "_out_row"},     32'(out_row), 0);
        chk({tag, "_busy"},        32'(busy), 0);
        chk({tag, "_done"},        32'(done), 0);
    endtask

    task automatic cyc();
        logic e_sr, e_rd, e_pe, e_clr, e_ov, e_busy, e_done;
        int e_addr, e_row, rel;
        logic [N-1:0] e_rv;
        e_sr = 1; e_rd = 0; e_pe = 0; e_clr = 0; e_ov = 0; e_busy = 0; e_done = 0;
        e_addr = 0; e_row = 0;
        if (m_act) begin
            rel = t - m_a;
            e_sr = 0;
            e_busy = 1;
            if (m_done_t == t) e_done = 1;
            else if (rel == 1) begin e_clr = 1; e_pe = 1; end
            else if (rel <= m_k + 1) begin e_rd = 1; e_addr = rel - 2; e_pe = 1; end
            else if (rel <= m_k + 1 + D) e_pe = 1;
            else begin e_ov = 1; e_row = m_x; end
        end
        for (int i = 0; i < N; i++) begin
            e_rv[i] = 1'b0;
            if (t - 1 - i >= 0) e_rv[i] = rlog[t - 1 - i];
        end
        rlog[t] = e_rd;
        chk("start_ready", 32'(start_ready), 32'(e_sr));
        chk("rd_en",       32'(rd_en),       32'(e_rd));
        chk("rd_addr",     32'(rd_addr),     32'(e_addr));
        chk("pe_enable",   32'(pe_enable),   32'(e_pe));
        chk("pe_clear",    32'(pe_clear),    32'(e_clr));
        chk("row_valid",   32'(row_valid),   32'(e_rv));
        chk("out_valid",   32'(out_valid),   32'(e_ov));
        chk("out_row",     32'(out_row),     32'(e_row));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("done",        32'(done),        32'(e_done));
        if (start_ready && start_valid) acc_t = t;
        if (done) done_t = t;
        if (!m_act && start_valid) begin
            m_act = 1; m_a = t; m_k = int'(start_k); m_x = 0; m_done_t = -1;
        end else if (m_act) begin
            if (m_done_t == t) m_act = 0;
            else if (e_ov && out_ready) begin
                m_x++;
                if (m_x == N) m_done_t = t + 1;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        start_valid = 0;
        reset = 0;
        #1;
        chk_idle("rst");
        m_act = 0;
        @(posedge clk); #1; t++;
        @(posedge clk); #1; t++;
        reset = 1;
        for (int j = 0; j <= t; j++) rlog[j] = 0;
    endtask

    task automatic run_cmd(input int k, input int stall_row, input int stall_len, input int exp_lat);
        int st = 0;
        int i = 0;
        bit seen = 0;
        start_k = K_W'(k);
        start_valid = 1;
        out_ready = 1;
        acc_t = -1;
        done_t = -1;
        cyc();
        start_valid = 0;
        while (!seen && i < 2000) begin
            out_ready = !(out_valid && int'(out_row) == stall_row && st < stall_len);
            if (!out_ready) st++;
            seen = (done === 1'b1);
            cyc();
            i++;
        end
        out_ready = 1;
        chk("done_latency", seen ? 32'(done_t - acc_t) : 32'hffff_ffff, 32'(exp_lat));
    endtask

    initial begin
        reset = 0;
        start_valid = 0;
        start_k = '0;
        out_ready = 1;
        #2;
        chk_idle("por");
        @(posedge clk); @(posedge clk); #1;
        reset = 1;
        t = 0;
        cyc();
        run_cmd(3, -1, 0, 3 + 2 + D + N);
        cyc();
        run_cmd(0, -1, 0, 2 + D + N);
        cyc();
        run_cmd(5, 2, 5, 5 + 2 + D + N + 5);
        cyc();
        run_cmd(255, -1, 0, 255 + 2 + D + N);
        cyc();
        start_valid = 1;
        for (int i = 0; i < 80; i++) begin
            start_k = K_W'($urandom_range(0, 6));
            cyc();
        end
        start_valid = 0;
        for (int i = 0; i < 300 && busy; i++) cyc();
        chk("drained_idle", 32'(busy), 0);
        start_k = 3;
        start_valid = 1;
        cyc();
        start_valid = 0;
        repeat (8) cyc();
        chk("in_drain", 32'(pe_enable && busy && !rd_en && !out_valid), 1);
        do_reset();
        cyc();
        run_cmd(3, -1, 0, 3 + 2 + D + N);
        for (int i = 0; i < 2500; i++) begin
            start_valid = $urandom_range(0, 3) != 0;
            start_k = ($urandom_range(0, 15) == 0) ? 8'd255 : K_W'($urandom_range(0, 12));
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
